// File: rtl/vdf_sq_seq.sv
// VDF squaring-chain sequencer: loads the multiplier's reduction RAM, then
// drives T dependent squarings through one accum_mult_mod, y = x^(2^T) mod p.
module vdf_sq_seq #(
  parameter int unsigned BITS     = 381,
  parameter int unsigned ITER_W   = 32,
  parameter int unsigned CTL_BITS = 8,
  parameter int unsigned RAM_D_W  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,

  input  logic                  i_cfg_val,
  input  logic [RAM_D_W-1:0]    i_cfg_dat,
  input  logic                  i_cfg_last,
  output logic                  o_cfg_rdy,

  input  logic                  i_start,
  input  logic [BITS-1:0]       i_x,
  input  logic [ITER_W-1:0]     i_iter,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [BITS-1:0]       o_y,
  output logic                  o_err,

  output logic                  o_mul_val,
  output logic [2*BITS-1:0]     o_mul_dat,
  output logic [CTL_BITS-1:0]   o_mul_ctl,
  input  logic                  i_mul_rdy,
  input  logic                  i_mul_val,
  input  logic [BITS-1:0]       i_mul_dat,
  input  logic [CTL_BITS-1:0]   i_mul_ctl,
  output logic                  o_mul_rdy,

  output logic [RAM_D_W-1:0]    o_ram_d,
  output logic                  o_ram_we,
  output logic                  o_ram_se
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CFG   = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]          state;
  logic                live;
  logic                cfg_ok;
  logic                cfg_acc;
  logic [BITS-1:0]     acc;
  logic [ITER_W-1:0]   cnt;
  logic [RAM_D_W-1:0]  ram_d;
  logic                ram_we;

  // live gates the state-decoded strobes so every output reads 0 while in reset
  assign o_cfg_rdy = live & ((state == S_IDLE) | (state == S_CFG));
  assign cfg_acc   = i_cfg_val & o_cfg_rdy;

  assign o_busy    = (state == S_ISSUE) | (state == S_WAIT);
  assign o_mul_val = (state == S_ISSUE);
  assign o_mul_rdy = (state == S_WAIT);
  assign o_mul_dat = {acc, acc};
  assign o_mul_ctl = cnt[CTL_BITS-1:0];

  assign o_ram_d   = ram_d;
  assign o_ram_we  = ram_we;
  // Session opens with the first accepted word and closes after the last delayed write
  assign o_ram_se  = live & ((state == S_CFG) | ram_we |
                             ((state == S_IDLE) & i_cfg_val));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state  <= S_IDLE;
      live   <= 1'b0;
      cfg_ok <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      ram_d  <= '0;
      ram_we <= 1'b0;
      o_done <= 1'b0;
      o_y    <= '0;
      o_err  <= 1'b0;
    end else begin
      live   <= 1'b1;
      o_done <= 1'b0;
      ram_we <= cfg_acc;
      if (cfg_acc) ram_d <= i_cfg_dat;

      case (state)
        S_IDLE: begin
          if (cfg_acc) begin
            cfg_ok <= i_cfg_last;
            state  <= i_cfg_last ? S_IDLE : S_CFG;
          end else if (i_start && cfg_ok) begin
            acc   <= i_x;
            cnt   <= i_iter;
            state <= (i_iter == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_CFG: begin
          if (cfg_acc && i_cfg_last) begin
            cfg_ok <= 1'b1;
            state  <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (i_mul_rdy) state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_mul_val) begin
            acc <= i_mul_dat;
            cnt <= cnt - 1'b1;
            if (i_mul_ctl != cnt[CTL_BITS-1:0]) o_err <= 1'b1;
            state <= (cnt == ITER_W'(1)) ? S_DONE : S_ISSUE;
          end
        end
        S_DONE: begin
          o_y    <= acc;
          o_done <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vdf_sq_seq.sv
// Directed bench for vdf_sq_seq with a behavioural modular-squaring multiplier.
module tb_vdf_sq_seq;
  localparam int unsigned BITS     = 381;
  localparam int unsigned ITER_W   = 32;
  localparam int unsigned CTL_BITS = 8;
  localparam int unsigned RAM_D_W  = 32;
  localparam int          LAT      = 10;
  localparam logic [BITS-1:0] MODULUS =
    381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;
  localparam logic [CTL_BITS-1:0] TAG_FLIP = 1;

  logic                i_clk = 1'b0;
  logic                i_rst = 1'b0;
  logic                i_cfg_val = 1'b0;
  logic [RAM_D_W-1:0]  i_cfg_dat = '0;
  logic                i_cfg_last = 1'b0;
  logic                o_cfg_rdy;
  logic                i_start = 1'b0;
  logic [BITS-1:0]     i_x = '0;
  logic [ITER_W-1:0]   i_iter = '0;
  logic                o_busy, o_done, o_err;
  logic [BITS-1:0]     o_y;
  logic                o_mul_val;
  logic [2*BITS-1:0]   o_mul_dat;
  logic [CTL_BITS-1:0] o_mul_ctl;
  logic                i_mul_rdy;
  logic                i_mul_val;
  logic [BITS-1:0]     i_mul_dat;
  logic [CTL_BITS-1:0] i_mul_ctl;
  logic                o_mul_rdy;
  logic [RAM_D_W-1:0]  o_ram_d;
  logic                o_ram_we, o_ram_se;

  vdf_sq_seq #(.BITS(BITS), .ITER_W(ITER_W), .CTL_BITS(CTL_BITS), .RAM_D_W(RAM_D_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cfg_val(i_cfg_val), .i_cfg_dat(i_cfg_dat), .i_cfg_last(i_cfg_last), .o_cfg_rdy(o_cfg_rdy),
    .i_start(i_start), .i_x(i_x), .i_iter(i_iter),
    .o_busy(o_busy), .o_done(o_done), .o_y(o_y), .o_err(o_err),
    .o_mul_val(o_mul_val), .o_mul_dat(o_mul_dat), .o_mul_ctl(o_mul_ctl), .i_mul_rdy(i_mul_rdy),
    .i_mul_val(i_mul_val), .i_mul_dat(i_mul_dat), .i_mul_ctl(i_mul_ctl), .o_mul_rdy(o_mul_rdy),
    .o_ram_d(o_ram_d), .o_ram_we(o_ram_we), .o_ram_se(o_ram_se)
  );

  always #5 i_clk = ~i_clk;

  logic any_out;
  assign any_out = |{o_cfg_rdy, o_busy, o_done, o_y, o_err, o_mul_val, o_mul_dat,
                     o_mul_ctl, o_mul_rdy, o_ram_d, o_ram_we, o_ram_se};

  int vectors = 0;
  int miscompares = 0;

  // multiplier model state
  bit                  pend = 0;
  int                  lat = 0;
  logic [BITS-1:0]     res = '0;
  logic [CTL_BITS-1:0] rtag = '0;
  int                  req_cnt = 0, resp_cnt = 0, corrupt_at = 0, halves_bad = 0;
  bit                  stall_en = 0, stall_done = 0;
  int                  stall_left = 0, stall_seen = 0, stall_bad = 0;
  logic [2*BITS-1:0]   stall_dat = '0;
  logic [CTL_BITS-1:0] tags[$];

  // All handshakes are resolved at the negedge, where both sides are stable until the next posedge.
  initial begin : mul_model
    logic [2*BITS-1:0] prod;
    i_mul_rdy = 1'b1; i_mul_val = 1'b0; i_mul_dat = '0; i_mul_ctl = '0;
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        pend = 0; i_mul_val = 1'b0; i_mul_rdy = 1'b1; stall_left = 0;
      end else begin
        if (stall_en && !stall_done && o_mul_val && req_cnt == 1) begin
          stall_left = 7; stall_done = 1; stall_dat = o_mul_dat;
        end
        i_mul_rdy = (stall_left == 0);
        if (stall_left > 0) begin
          stall_seen++;
          if (o_mul_val !== 1'b1 || o_mul_dat !== stall_dat) stall_bad++;
          stall_left--;
        end
        i_mul_val = pend && (lat == 0);
        if (i_mul_val) begin
          i_mul_dat = res;
          i_mul_ctl = (resp_cnt + 1 == corrupt_at) ? (rtag ^ TAG_FLIP) : rtag;
        end
        if (i_mul_val && o_mul_rdy) begin
          pend = 0; resp_cnt++;
        end else if (pend && lat > 0) begin
          lat--;
        end
        if (o_mul_val && i_mul_rdy) begin
          req_cnt++;
          tags.push_back(o_mul_ctl);
          if (o_mul_dat[BITS-1:0] !== o_mul_dat[2*BITS-1:BITS]) halves_bad++;
          prod = {{BITS{1'b0}}, o_mul_dat[BITS-1:0]} * {{BITS{1'b0}}, o_mul_dat[2*BITS-1:BITS]};
          prod = prod % {{BITS{1'b0}}, MODULUS};
          res  = prod[BITS-1:0];
          rtag = o_mul_ctl;
          pend = 1; lat = LAT;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic model_clear();
    req_cnt = 0; resp_cnt = 0; halves_bad = 0; tags.delete();
    stall_done = 0; stall_seen = 0; stall_bad = 0;
  endtask

  task automatic run_chain(input logic [BITS-1:0] x, input logic [ITER_W-1:0] t, input int budget,
                           output int done_cyc, output int pulses, output logic [BITS-1:0] y,
                           output int val_cycles);
    done_cyc = -1; pulses = 0; y = '0; val_cycles = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge i_clk);
      i_start = (c == 0); i_x = x; i_iter = t;
      #1;
      if (c == 0) model_clear();
      if (o_mul_val) val_cycles++;
      if (o_done) begin
        pulses++;
        if (done_cyc < 0) begin done_cyc = c; y = o_y; end
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    #1;
    vectors++;
    if (any_out !== 1'b0) begin
      miscompares++; $display("FAIL reset_outputs: or-of-outputs=%b expected 0", any_out);
    end
    @(negedge i_clk); i_rst = 1'b1;
    @(negedge i_clk); #1;
    vectors++;
    if (o_cfg_rdy !== 1'b1) begin
      miscompares++; $display("FAIL reset_cfg_rdy: got %b expected 1", o_cfg_rdy);
    end
  endtask

  task automatic test_start_no_cfg();
    int busy_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      i_start = (c == 0); i_x = 5; i_iter = 3;
      #1;
      if (o_busy || o_mul_val) busy_seen++;
    end
    i_start = 1'b0;
    vectors++;
    if (busy_seen !== 0) begin
      miscompares++; $display("FAIL start_no_cfg: busy cycles=%0d expected 0", busy_seen);
    end
  endtask

  task automatic test_cfg_load();
    logic [RAM_D_W-1:0] w [4];
    int rdy_bad = 0, se_cnt = 0, we_cnt = 0, d_bad = 0;
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      i_cfg_val  = (c < 4);
      i_cfg_dat  = (c < 4) ? w[c] : '0;
      i_cfg_last = (c == 3);
      #1;
      if (c < 4 && o_cfg_rdy !== 1'b1) rdy_bad++;
      if (o_ram_se) se_cnt++;
      if (o_ram_we) begin
        if (we_cnt < 4 && o_ram_d !== w[we_cnt]) d_bad++;
        we_cnt++;
      end
    end
    i_cfg_val = 1'b0; i_cfg_last = 1'b0;
    vectors++;
    if (rdy_bad !== 0) begin miscompares++; $display("FAIL cfg_rdy: refused=%0d expected 0", rdy_bad); end
    vectors++;
    if (we_cnt !== 4) begin miscompares++; $display("FAIL cfg_we_count: got %0d expected 4", we_cnt); end
    vectors++;
    if (d_bad !== 0) begin miscompares++; $display("FAIL cfg_ram_d: wrong words=%0d expected 0", d_bad); end
    vectors++;
    if (se_cnt !== 5) begin miscompares++; $display("FAIL cfg_se_cycles: got %0d expected 5", se_cnt); end
    vectors++;
    if (o_ram_se !== 1'b0) begin miscompares++; $display("FAIL cfg_se_drop: got %b expected 0", o_ram_se); end
  endtask

  task automatic test_chain();
    int dc, pl, vc, tag_bad;
    logic [BITS-1:0] y;
    run_chain(2, 5, 400, dc, pl, y, vc);
    vectors++;
    if (dc < 0) begin miscompares++; $display("FAIL chain_timeout: no o_done within budget"); end
    vectors++;
    if (y !== BITS'(64'h1_0000_0000)) begin
      miscompares++; $display("FAIL chain_y: got %0h expected 100000000", y);
    end
    vectors++;
    if (pl !== 1) begin miscompares++; $display("FAIL chain_done_pulses: got %0d expected 1", pl); end
    vectors++;
    if (req_cnt !== 5) begin miscompares++; $display("FAIL chain_requests: got %0d expected 5", req_cnt); end
    tag_bad = 0;
    foreach (tags[i]) if (tags[i] !== CTL_BITS'(5 - i)) tag_bad++;
    vectors++;
    if (tag_bad !== 0 || halves_bad !== 0) begin
      miscompares++; $display("FAIL chain_tags_operands: bad tags=%0d bad operands=%0d expected 0,0", tag_bad, halves_bad);
    end
    vectors++;
    if (o_err !== 1'b0) begin miscompares++; $display("FAIL chain_err: got %b expected 0", o_err); end
  endtask

  task automatic test_t0();
    int dc, pl, vc;
    logic [BITS-1:0] y;
    run_chain(BITS'(16'h1234), 0, 20, dc, pl, y, vc);
    vectors++;
    if (dc !== 2) begin miscompares++; $display("FAIL t0_latency: done at cycle %0d expected 2", dc); end
    vectors++;
    if (y !== BITS'(16'h1234)) begin miscompares++; $display("FAIL t0_y: got %0h expected 1234", y); end
    vectors++;
    if (vc !== 0) begin miscompares++; $display("FAIL t0_mul_val: cycles=%0d expected 0", vc); end
    vectors++;
    if (pl !== 1) begin miscompares++; $display("FAIL t0_done_pulses: got %0d expected 1", pl); end
  endtask

  task automatic test_backpressure();
    int dc, pl, vc;
    logic [BITS-1:0] y;
    stall_en = 1;
    run_chain(MODULUS - 1'b1, 3, 400, dc, pl, y, vc);
    stall_en = 0;
    vectors++;
    if (stall_seen !== 7) begin miscompares++; $display("FAIL bp_stall_cycles: got %0d expected 7", stall_seen); end
    vectors++;
    if (stall_bad !== 0) begin miscompares++; $display("FAIL bp_stable: unstable cycles=%0d expected 0", stall_bad); end
    vectors++;
    if (y !== BITS'(1)) begin miscompares++; $display("FAIL bp_y: got %0h expected 1", y); end
    vectors++;
    if (req_cnt !== 3) begin miscompares++; $display("FAIL bp_requests: got %0d expected 3", req_cnt); end
  endtask

  task automatic test_tag_err();
    int dc, pl, vc;
    logic [BITS-1:0] y;
    vectors++;
    if (o_err !== 1'b0) begin miscompares++; $display("FAIL err_pre: got %b expected 0", o_err); end
    corrupt_at = 3;
    run_chain(3, 4, 400, dc, pl, y, vc);
    corrupt_at = 0;
    vectors++;
    if (dc < 0) begin miscompares++; $display("FAIL err_timeout: no o_done within budget"); end
    vectors++;
    if (y !== BITS'(32'h290D741)) begin miscompares++; $display("FAIL err_chain_y: got %0h expected 290d741", y); end
    vectors++;
    if (o_err !== 1'b1) begin miscompares++; $display("FAIL err_set: got %b expected 1", o_err); end
    repeat (5) @(negedge i_clk);
    #1;
    vectors++;
    if (o_err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b expected 1", o_err); end
  endtask

  task automatic test_reset_mid_chain();
    int dc, pl, vc, busy_seen;
    logic [BITS-1:0] y;
    @(negedge i_clk);
    i_start = 1'b1; i_x = 2; i_iter = 10;
    #1; model_clear();
    @(negedge i_clk); i_start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge i_clk); #1;
      if (req_cnt >= 3) break;
    end
    vectors++;
    if (req_cnt < 3) begin miscompares++; $display("FAIL rst_mid_reach: requests=%0d expected 3", req_cnt); end
    #2; i_rst = 1'b0; #1;
    vectors++;
    if (any_out !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_async: or-of-outputs=%b expected 0", any_out);
    end
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    busy_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      i_start = (c == 1); i_x = 5; i_iter = 2;
      #1;
      if (o_busy || o_mul_val || o_done) busy_seen++;
    end
    i_start = 1'b0;
    vectors++;
    if (busy_seen !== 0) begin miscompares++; $display("FAIL rst_cfg_cleared: busy cycles=%0d expected 0", busy_seen); end
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      i_cfg_val = (c < 2); i_cfg_dat = (c == 0) ? 32'hA5 : 32'h5A; i_cfg_last = (c == 1);
    end
    i_cfg_val = 1'b0; i_cfg_last = 1'b0;
    run_chain(5, 2, 200, dc, pl, y, vc);
    vectors++;
    if (y !== BITS'(625)) begin miscompares++; $display("FAIL rst_reload_y: got %0h expected 271", y); end
  endtask

  initial begin
    test_reset();
    test_start_no_cfg();
    test_cfg_load();
    test_chain();
    test_t0();
    test_backpressure();
    test_tag_err();
    test_reset_mid_chain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
